// File: rtl/blink_sweep_ctrl_if.sv
// Control interface between blink_sweep_ctrl and its surroundings.
// The master modport is the controller side. The slave modport is the
// board/config side that drives buttons, mode and LED feedback and consumes
// the step pulses.
interface blink_sweep_ctrl_if #(
    parameter int unsigned FREQ_STEPS = 50,
    parameter int unsigned NUM_SWEEPS = 3
);
    logic                                auto_en_i;
    logic                                btn_up_i;
    logic                                btn_dwn_i;
    logic                                led_i;
    logic                                freq_up_o;
    logic                                freq_dwn_o;
    logic [$clog2(FREQ_STEPS+1)-1:0]     step_o;
    logic                                dir_o;
    logic [$clog2(NUM_SWEEPS+2)-1:0]     sweeps_o;
    logic                                done_o;

    modport master (
        input  auto_en_i, btn_up_i, btn_dwn_i, led_i,
        output freq_up_o, freq_dwn_o, step_o, dir_o, sweeps_o, done_o
    );

    modport slave (
        output auto_en_i, btn_up_i, btn_dwn_i, led_i,
        input  freq_up_o, freq_dwn_o, step_o, dir_o, sweeps_o, done_o
    );
endinterface

// File: rtl/blink_sweep_ctrl.sv
// blink_sweep_ctrl: step-sequencing controller for blink_led.
// Auto mode counts LED rising edges and sweeps the step pointer
// MIN->MAX->MIN for NUM_SWEEPS sweeps (0 = forever). Manual mode turns
// push-button edges into single step pulses.
// Optional feature macro: BLINK_SWEEP_DEBOUNCE_EN adds a counter debouncer
// (DEBOUNCE_CYCLES) behind each button synchronizer.
module blink_sweep_ctrl #(
    parameter int unsigned FREQ_STEPS      = 50,
    parameter int unsigned PULSES_PER_STEP = 2,
    parameter int unsigned NUM_SWEEPS      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    blink_sweep_ctrl_if.master    bus
);

    localparam int unsigned SW = $clog2(FREQ_STEPS + 1);
    localparam int unsigned CW = $clog2(NUM_SWEEPS + 2);
    localparam int unsigned PW = $clog2(PULSES_PER_STEP + 1);

    localparam logic [SW-1:0] STEP_MAX   = SW'(FREQ_STEPS);
    localparam logic [PW-1:0] PCNT_LAST  = PW'(PULSES_PER_STEP - 1);
    localparam logic [CW-1:0] SWEEP_GOAL = CW'(NUM_SWEEPS);

    if (FREQ_STEPS < 1 || PULSES_PER_STEP < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("blink_sweep_ctrl: FREQ_STEPS, PULSES_PER_STEP and DEBOUNCE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        STEP,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Bit order in the input pipeline: [2] = btn_dwn, [1] = btn_up, [0] = led.
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [1:0]    w_btn_lvl;
    logic [2:0]    w_lvl;
    logic [2:0]    r_prev;
    logic [2:0]    r_edge;

    logic          r_freq_up;
    logic          r_freq_dwn;
    logic [SW-1:0] r_step;
    logic          r_dir;
    logic [CW-1:0] r_sweeps;
    logic          r_done;
    logic [PW-1:0] r_pcnt;

    logic          w_freq_up_nxt;
    logic          w_freq_dwn_nxt;
    logic [SW-1:0] w_step_nxt;
    logic          w_dir_nxt;
    logic [CW-1:0] w_sweeps_nxt;
    logic          w_done_nxt;
    logic [PW-1:0] w_pcnt_nxt;

    logic          w_led_edge;
    logic          w_up_edge;
    logic          w_dwn_edge;
    logic          w_pulse_last;
    logic          w_at_max;
    logic          w_at_min;
    logic          w_dir_eff;
    logic [SW-1:0] w_step_new;
    logic          w_turn_down;
    logic          w_turn_up;
    logic          w_dir_new;
    logic [CW-1:0] w_sweeps_inc;
    logic [CW-1:0] w_sweeps_new;
    logic          w_done_hit;

    // Two-flop synchronizers for the asynchronous LED and button inputs
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {bus.btn_dwn_i, bus.btn_up_i, bus.led_i};
            r_sync2 <= r_sync1;
        end
    end

`ifdef BLINK_SWEEP_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0][DW-1:0] r_db_cnt;
    logic [1:0]         r_db_lvl;

    // Button level follows the synced input only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_db_cnt <= '0;
            r_db_lvl <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i+1] != r_db_lvl[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db_lvl[i] <= r_sync2[i+1];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_btn_lvl = r_db_lvl;
`else
    assign w_btn_lvl = r_sync2[2:1];
`endif

    assign w_lvl = {w_btn_lvl, r_sync2[0]};

    // Registered rising-edge detectors; the extra stage sets the 4-cycle LED-to-pulse latency
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_prev <= '0;
            r_edge <= '0;
        end else begin
            r_prev <= w_lvl;
            r_edge <= w_lvl & ~r_prev;
        end
    end

    assign w_led_edge   = r_edge[0];
    assign w_up_edge    = r_edge[1];
    assign w_dwn_edge   = r_edge[2];
    assign w_pulse_last = r_freq_up | r_freq_dwn;

    // Auto-step arithmetic. If manual moves left the pointer at a limit with
    // the direction still pointing outward, turn around instead of wrapping.
    assign w_at_max     = (r_step == STEP_MAX);
    assign w_at_min     = (r_step == '0);
    assign w_dir_eff    = r_dir ? !w_at_min : w_at_max;
    assign w_step_new   = w_dir_eff ? (r_step - 1'b1) : (r_step + 1'b1);
    assign w_turn_down  = !w_dir_eff && (w_step_new == STEP_MAX);
    assign w_turn_up    = w_dir_eff && (w_step_new == '0);
    assign w_dir_new    = w_turn_down ? 1'b1 : (w_turn_up ? 1'b0 : w_dir_eff);
    assign w_sweeps_inc = (r_sweeps == '1) ? r_sweeps : (r_sweeps + 1'b1);
    assign w_sweeps_new = w_turn_up ? w_sweeps_inc : r_sweeps;
    assign w_done_hit   = (NUM_SWEEPS != 0) && (w_sweeps_new == SWEEP_GOAL);

    // FSM state register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.auto_en_i) begin
                    w_state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (!bus.auto_en_i) begin
                    w_state_nxt = IDLE;
                end else if (w_led_edge && (r_pcnt == PCNT_LAST)) begin
                    w_state_nxt = STEP;
                end
            end
            STEP: begin
                // Reaching the sweep goal wins over a simultaneous disable so
                // sweeps_o is always cleared through DONE.
                if (w_done_hit) begin
                    w_state_nxt = DONE;
                end else if (!bus.auto_en_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_RISE;
                end
            end
            DONE: begin
                if (!bus.auto_en_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs and pulse counter
    always_comb begin
        w_freq_up_nxt  = 1'b0;
        w_freq_dwn_nxt = 1'b0;
        w_step_nxt     = r_step;
        w_dir_nxt      = r_dir;
        w_sweeps_nxt   = r_sweeps;
        w_pcnt_nxt     = r_pcnt;
        w_done_nxt     = (w_state_nxt == DONE);
        unique case (r_state)
            IDLE: begin
                w_pcnt_nxt = '0;
                // Simultaneous edges cancel; an edge right after any pulse is dropped
                if (!bus.auto_en_i && !w_pulse_last && (w_up_edge != w_dwn_edge)) begin
                    if (w_up_edge && !w_at_max) begin
                        w_freq_up_nxt = 1'b1;
                        w_step_nxt    = r_step + 1'b1;
                    end else if (w_dwn_edge && !w_at_min) begin
                        w_freq_dwn_nxt = 1'b1;
                        w_step_nxt     = r_step - 1'b1;
                    end
                end
            end
            WAIT_RISE: begin
                if (!bus.auto_en_i) begin
                    w_pcnt_nxt = '0;
                end else if (w_led_edge) begin
                    w_pcnt_nxt = (r_pcnt == PCNT_LAST) ? '0 : (r_pcnt + 1'b1);
                end
            end
            STEP: begin
                w_freq_up_nxt  = !w_dir_eff;
                w_freq_dwn_nxt = w_dir_eff;
                w_step_nxt     = w_step_new;
                w_dir_nxt      = w_dir_new;
                w_sweeps_nxt   = w_sweeps_new;
                w_pcnt_nxt     = '0;
            end
            DONE: begin
                if (!bus.auto_en_i) begin
                    w_sweeps_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    // Output and pulse-counter registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_freq_up  <= 1'b0;
            r_freq_dwn <= 1'b0;
            r_step     <= '0;
            r_dir      <= 1'b0;
            r_sweeps   <= '0;
            r_done     <= 1'b0;
            r_pcnt     <= '0;
        end else begin
            r_freq_up  <= w_freq_up_nxt;
            r_freq_dwn <= w_freq_dwn_nxt;
            r_step     <= w_step_nxt;
            r_dir      <= w_dir_nxt;
            r_sweeps   <= w_sweeps_nxt;
            r_done     <= w_done_nxt;
            r_pcnt     <= w_pcnt_nxt;
        end
    end

    assign bus.freq_up_o  = r_freq_up;
    assign bus.freq_dwn_o = r_freq_dwn;
    assign bus.step_o     = r_step;
    assign bus.dir_o      = r_dir;
    assign bus.sweeps_o   = r_sweeps;
    assign bus.done_o     = r_done;

endmodule
